// File: rtl/apb_bridge_ctrl_param.sv
// AHB-lite to APB3/APB4 master controller: decodes one of NUM_SLV slaves, runs SETUP/ACCESS with
// wait states, and folds pslverr, decode misses, illegal sizes and timeouts into the AHB ERROR pair.
module apb_bridge_ctrl_param #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic                      hsel,
  input  logic [1:0]                htrans,
  input  logic                      hwrite,
  input  logic [2:0]                hsize,
  input  logic [ADDR_W-1:0]         haddr,
  input  logic [DATA_W-1:0]         hwdata,
  input  logic                      hready_in,
  output logic                      hready_out,
  output logic [1:0]                hresp,
  output logic [DATA_W-1:0]         hrdata,
  output logic [ADDR_W-1:0]         paddr,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  output logic [DATA_W/8-1:0]       pstrb,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);
  localparam int STRB_W = DATA_W / 8;
  localparam int K      = $clog2(STRB_W);
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, LATCH, SETUP, ACCESS, DONE, ERR1, ERR2} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0]  addr_q;
  logic               write_q;
  logic [2:0]         size_q;
  logic [3:0]         idx_q;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W:0]     cnt_inc;

  logic               accept;
  logic               bad_req;
  logic               sel_rdy;
  logic               sel_err;
  logic               tmo_hit;
  logic [DATA_W-1:0]  sel_rdata;
  logic [NUM_SLV-1:0] sel_onehot;
  logic [STRB_W-1:0]  strb_calc;

  // AHB-side handshake is a pure decode of the registered state.
  assign hready_out = (state == IDLE) || (state == DONE) || (state == ERR2);
  assign hresp      = ((state == ERR1) || (state == ERR2)) ? 2'b01 : 2'b00;
  assign accept     = hsel & htrans[1] & hready_in & hready_out;

  assign bad_req = ({1'b0, idx_q} >= 5'(NUM_SLV)) || (size_q > 3'(K));
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
  assign tmo_hit = (TIMEOUT != 0) && (cnt_inc >= (CNT_W+1)'(TIMEOUT));

  // Only the decoded slave's response is observed; the others are ignored.
  always_comb begin
    sel_onehot = '0;
    sel_rdy    = 1'b0;
    sel_err    = 1'b0;
    sel_rdata  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == 4'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_rdy       = pready[i];
        sel_err       = pslverr[i];
        sel_rdata     = prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // A lane is enabled when it falls in the same size-aligned block as the address.
  always_comb begin
    strb_calc = '0;
    for (int b = 0; b < STRB_W; b++) begin
      strb_calc[b] = ((b >> size_q) == (int'(addr_q[K-1:0]) >> size_q));
    end
    if (!write_q) strb_calc = '0;
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR2: state_nxt = accept ? LATCH : IDLE;
      LATCH:            state_nxt = bad_req ? ERR1 : SETUP;
      SETUP:            state_nxt = ACCESS;
      ACCESS: begin
        if (sel_rdy)      state_nxt = sel_err ? ERR1 : DONE;
        else if (tmo_hit) state_nxt = ERR1;
      end
      ERR1:             state_nxt = ERR2;
      default:          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      idx_q   <= '0;
      cnt     <= '0;
      paddr   <= '0;
      psel    <= '0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      pwdata  <= '0;
      pstrb   <= '0;
      hrdata  <= '0;
    end else begin
      if (accept) begin
        addr_q  <= haddr;
        write_q <= hwrite;
        size_q  <= hsize;
        idx_q   <= haddr[SEL_LSB+3:SEL_LSB];
      end
      case (state)
        LATCH: begin
          pstrb <= strb_calc;
          if (write_q) pwdata <= hwdata;
          if (!bad_req) begin
            paddr  <= addr_q;
            pwrite <= write_q;
            psel   <= sel_onehot;
            cnt    <= '0;
          end
        end
        SETUP: penable <= 1'b1;
        ACCESS: begin
          if (!sel_rdy && (cnt != '1)) cnt <= cnt_inc[CNT_W-1:0];
          if (state_nxt != ACCESS) begin
            psel    <= '0;
            penable <= 1'b0;
            if (sel_rdy && !sel_err && !write_q) hrdata <= sel_rdata;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_bridge_ctrl_param.sv
// Bench: a 32-bit/4-slave/TIMEOUT=16 instance under random and directed transfers, plus a
// 64-bit/2-slave instance with the timeout disabled for wide strobes and long waits.
`timescale 1ns/1ps
module tb_apb_bridge_ctrl_param;
  localparam int TMO = 16;

  logic hclk = 1'b0;
  always #5 hclk = ~hclk;
  logic hreset;

  logic         hsel, hwrite, hready_in, hready_out, penable, pwrite;
  logic [1:0]   htrans, hresp;
  logic [2:0]   hsize;
  logic [31:0]  haddr, hwdata, hrdata, paddr, pwdata;
  logic [3:0]   psel, pstrb, pready, pslverr;
  logic [127:0] prdata;

  logic         hsel_b, hwrite_b, hready_in_b, hready_out_b, penable_b, pwrite_b;
  logic [1:0]   htrans_b, hresp_b;
  logic [2:0]   hsize_b;
  logic [31:0]  haddr_b, paddr_b;
  logic [63:0]  hwdata_b, hrdata_b, pwdata_b;
  logic [1:0]   psel_b, pready_b, pslverr_b;
  logic [7:0]   pstrb_b;
  logic [127:0] prdata_b;

  apb_bridge_ctrl_param #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SEL_LSB(12), .TIMEOUT(TMO)) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .haddr(haddr), .hwdata(hwdata), .hready_in(hready_in), .hready_out(hready_out), .hresp(hresp),
    .hrdata(hrdata), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr));

  apb_bridge_ctrl_param #(.ADDR_W(32), .DATA_W(64), .NUM_SLV(2), .SEL_LSB(12), .TIMEOUT(0)) dut_b (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_b), .htrans(htrans_b), .hwrite(hwrite_b), .hsize(hsize_b),
    .haddr(haddr_b), .hwdata(hwdata_b), .hready_in(hready_in_b), .hready_out(hready_out_b),
    .hresp(hresp_b), .hrdata(hrdata_b), .paddr(paddr_b), .psel(psel_b), .penable(penable_b),
    .pwrite(pwrite_b), .pwdata(pwdata_b), .pstrb(pstrb_b), .prdata(prdata_b), .pready(pready_b),
    .pslverr(pslverr_b));

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] hrdata_exp;
  logic [63:0] hrdata_b_exp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Lanes covered by a naturally sized access: the size-aligned block containing the address.
  function automatic logic [7:0] exp_strb(input logic [31:0] a, input int sz, input bit wr, input int bus_bytes);
    int nb, off;
    if (!wr) return 8'h00;
    nb  = 1 << sz;
    off = (int'(a % 32'(bus_bytes)) / nb) * nb;
    return 8'(((1 << nb) - 1) << off);
  endfunction

  task automatic step();
    @(posedge hclk);
    @(negedge hclk);
  endtask

  // One AHB transfer on the 32-bit bridge with a scripted slave: w wait cycles, then ready with err.
  task automatic xfer(input logic [31:0] addr, input bit wr, input int sz, input logic [31:0] wd,
                      input int w, input bit err, input logic [31:0] rdata, input int rst_at);
    int idx, acc, setup_n, cyc, err1_n, busy, unstable, exp_acc, exp_lat;
    bit legal, exp_err;
    logic [3:0] s_psel, s_pstrb;
    logic [31:0] s_paddr, s_pwdata;
    logic s_pwrite;
    idx   = int'(addr[15:12]);
    legal = (idx < 4) && (sz <= 2);
    if (!legal)                  begin exp_acc = 0;     exp_err = 1'b1; end
    else if (TMO != 0 && w >= TMO) begin exp_acc = TMO; exp_err = 1'b1; end
    else                         begin exp_acc = w + 1; exp_err = err;  end
    exp_lat = !legal ? 3 : (2 + exp_acc + (exp_err ? 2 : 1));
    for (int i = 0; i < 4; i++) prdata[i*32 +: 32] = $urandom;
    if (idx < 4) prdata[idx*32 +: 32] = rdata;
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = 3'(sz); hready_in = 1'b1;
    step();
    hsel = 1'b0; htrans = 2'b00; hwdata = wd; haddr = $urandom; hwrite = 1'($urandom); hsize = 3'($urandom);
    acc = 0; setup_n = 0; cyc = 1; err1_n = 0; busy = 0; unstable = 0;
    s_psel = '0; s_pstrb = '0; s_paddr = '0; s_pwdata = '0; s_pwrite = 1'b0;
    forever begin
      if (psel != 0) busy++;
      if (psel != 0 && !penable) begin
        setup_n++;
        s_psel = psel; s_pstrb = pstrb; s_paddr = paddr; s_pwdata = pwdata; s_pwrite = pwrite;
      end
      if (penable) begin
        acc++;
        if (psel !== s_psel || paddr !== s_paddr || pstrb !== s_pstrb || pwrite !== s_pwrite ||
            pwdata !== s_pwdata) unstable++;
      end
      if (!hready_out && hresp == 2'b01) err1_n++;
      if (rst_at != 0 && acc == rst_at) begin
        hreset = 1'b1;
        #1;
        chk("rst_async_psel", psel, 0);
        chk("rst_async_penable", penable, 0);
        chk("rst_async_hready_out", hready_out, 1);
        @(negedge hclk);
        hreset = 1'b0; pready = '0; pslverr = '0;
        step();
        chk("rst_release_idle_hready", hready_out, 1);
        chk("rst_release_idle_psel", psel, 0);
        hrdata_exp = '0;
        chk("rst_hrdata", hrdata, hrdata_exp);
        return;
      end
      if (hready_out) break;
      if (cyc > 200) begin
        chk("xfer_bound", cyc, exp_lat);
        break;
      end
      pready = 4'($urandom); pslverr = 4'($urandom);
      if (penable) begin
        pready[idx]  = (acc > w);
        pslverr[idx] = err;
      end
      step();
      cyc++;
    end
    chk("latency", cyc, exp_lat);
    chk("hresp_end", hresp, exp_err ? 2'b01 : 2'b00);
    chk("err1_cycles", err1_n, exp_err ? 1 : 0);
    chk("access_cycles", acc, exp_acc);
    chk("setup_cycles", setup_n, legal ? 1 : 0);
    chk("psel_busy_cycles", busy, legal ? exp_acc + 1 : 0);
    chk("apb_stable", unstable, 0);
    if (legal) begin
      chk("psel", s_psel, 4'b0001 << idx);
      chk("paddr", s_paddr, addr);
      chk("pwrite", s_pwrite, wr);
      chk("pstrb", s_pstrb, exp_strb(addr, sz, wr, 4));
      if (wr) chk("pwdata", s_pwdata, wd);
    end
    if (legal && !exp_err && !wr) hrdata_exp = rdata;
    chk("hrdata", hrdata, hrdata_exp);
  endtask

  // Transfer on the 64-bit bridge; its timeout is disabled so any wait count must complete.
  task automatic xfer64(input logic [31:0] addr, input bit wr, input int sz, input int w,
                        input logic [63:0] rdata);
    int idx, acc, cyc, exp_lat;
    logic [1:0] s_psel;
    logic [7:0] s_pstrb;
    logic [31:0] s_paddr;
    logic [63:0] wd;
    idx = int'(addr[15:12]);
    exp_lat = 2 + (w + 1) + 1;
    wd = {$urandom, $urandom};
    prdata_b = {$urandom, $urandom, $urandom, $urandom};
    prdata_b[idx*64 +: 64] = rdata;
    hsel_b = 1'b1; htrans_b = 2'b10; haddr_b = addr; hwrite_b = wr; hsize_b = 3'(sz); hready_in_b = 1'b1;
    step();
    hsel_b = 1'b0; htrans_b = 2'b00; hwdata_b = wd;
    acc = 0; cyc = 1; s_psel = '0; s_pstrb = '0; s_paddr = '0;
    forever begin
      if (psel_b != 0 && !penable_b) begin s_psel = psel_b; s_pstrb = pstrb_b; s_paddr = paddr_b; end
      if (penable_b) acc++;
      if (hready_out_b) break;
      if (cyc > 300) begin
        chk("b_xfer_bound", cyc, exp_lat);
        break;
      end
      pready_b = 2'($urandom); pslverr_b = 2'($urandom);
      if (penable_b) begin
        pready_b[idx]  = (acc > w);
        pslverr_b[idx] = 1'b0;
      end
      step();
      cyc++;
    end
    chk("b_latency", cyc, exp_lat);
    chk("b_access_cycles", acc, w + 1);
    chk("b_hresp", hresp_b, 2'b00);
    chk("b_psel", s_psel, 2'b01 << idx);
    chk("b_paddr", s_paddr, addr);
    chk("b_pstrb", s_pstrb, exp_strb(addr, sz, wr, 8));
    if (wr) chk("b_pwdata", pwdata_b, wd);
    else    hrdata_b_exp = rdata;
    chk("b_hrdata", hrdata_b, hrdata_b_exp);
  endtask

  initial begin
    logic [31:0] a;
    int sz, w;
    bit wr, er;
    hreset = 1'b1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = '0; haddr = '0; hwdata = '0; hready_in = 1'b1;
    prdata = '0; pready = '0; pslverr = '0;
    hsel_b = 1'b0; htrans_b = 2'b00; hwrite_b = 1'b0; hsize_b = '0; haddr_b = '0; hwdata_b = '0;
    hready_in_b = 1'b1; prdata_b = '0; pready_b = '0; pslverr_b = '0;
    hrdata_exp = '0; hrdata_b_exp = '0;
    #12;
    chk("rst_hready_out", hready_out, 1);
    chk("rst_hresp", hresp, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pstrb", pstrb, 0);
    chk("rst_hrdata", hrdata, 0);
    chk("rst_b_hready_out", hready_out_b, 1);
    chk("rst_b_psel", psel_b, 0);
    @(negedge hclk);
    hreset = 1'b0;
    step();

    // Transfers that must not be accepted leave the bridge ready.
    hsel = 1'b1; htrans = 2'b10; hready_in = 1'b0; haddr = 32'h1000;
    step();
    chk("no_accept_hready_in_low", hready_out, 1);
    hready_in = 1'b1; htrans = 2'b00;
    step();
    chk("no_accept_htrans_idle", hready_out, 1);
    htrans = 2'b01;
    step();
    chk("no_accept_htrans_busy", hready_out, 1);
    hsel = 1'b0; htrans = 2'b00;
    step();

    xfer(32'h0000_1004, 1'b1, 2, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 0);
    xfer(32'h0000_2010, 1'b0, 2, 32'h0, 3, 1'b0, 32'h1234_5678, 0);
    xfer(32'h0000_3000, 1'b1, 2, 32'hCAFE_F00D, 0, 1'b1, 32'h0, 0);
    xfer(32'h0000_0008, 1'b0, 2, 32'h0, 1, 1'b0, 32'hA5A5_0001, 0);
    xfer(32'h0000_7000, 1'b0, 2, 32'h0, 0, 1'b0, 32'h0, 0);
    xfer(32'h0000_1000, 1'b1, 3, 32'h1111_2222, 0, 1'b0, 32'h0, 0);
    xfer(32'h0000_3001, 1'b1, 0, 32'h0000_5500, 0, 1'b0, 32'h0, 0);
    xfer(32'h0000_1002, 1'b1, 1, 32'h7777_0000, 2, 1'b0, 32'h0, 0);
    xfer(32'h0000_3004, 1'b0, 2, 32'h0, 40, 1'b0, 32'hBAD0_BAD0, 0);
    xfer(32'h0000_1000, 1'b0, 2, 32'h0, 10, 1'b0, 32'h0, 3);
    xfer(32'h0000_2000, 1'b0, 2, 32'h0, 0, 1'b0, 32'h0BAD_CAFE, 0);

    for (int t = 0; t < 60; t++) begin
      a = $urandom;
      a[15:12] = 4'($urandom_range(0, 5));
      sz = $urandom_range(0, 3);
      wr = 1'($urandom_range(0, 1));
      er = ($urandom_range(0, 3) == 0);
      w  = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 18) : $urandom_range(0, 3);
      xfer(a, wr, sz, $urandom, w, er, $urandom, 0);
      repeat ($urandom_range(0, 2)) step();
    end

    xfer64(32'h0000_0005, 1'b1, 0, 0, 64'h0);
    xfer64(32'h0000_1006, 1'b1, 1, 2, 64'h0);
    xfer64(32'h0000_0004, 1'b1, 2, 0, 64'h0);
    xfer64(32'h0000_1000, 1'b1, 3, 1, 64'h0);
    xfer64(32'h0000_1008, 1'b0, 3, 40, 64'h0123_4567_89AB_CDEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
